psum_accumulator: RTL

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 17 +
 rtl/psum_lane_adder.sv | 53 +++++
 rtl/psum_accumulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared types and default sizing for the partial-sum accumulator.
// Holds the drain FSM state type and the default parameter values used by
// psum_accumulator and psum_lane_adder.
package psum_accumulator_pkg;

  localparam int unsigned PSUM_VECTOR_WIDTH_DEF          = 4;
  localparam int unsigned PSUM_NO_VECTORS_DEF            = 16;
  localparam int unsigned PSUM_DATA_WIDTH_DEF            = 16;
  localparam int unsigned PSUM_ACC_WIDTH_DEF             = 32;
  localparam int unsigned PSUM_VECTOR_SELECTOR_WIDTH_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } psum_state_e;

endpackage

// File: rtl/psum_lane_adder.sv
// One accumulator lane: sign-extends a partial sum and either loads it
// (clear) or adds it to the running accumulator value.
// Build option: ACC_SATURATE_EN -- when defined the add clamps to the signed
// ACC_WIDTH range and flags overflow; otherwise it wraps and overflow is 0.
// Ports:
//   in_data  - signed partial sum, DATA_WIDTH bits
//   acc_in   - current accumulator value, ACC_WIDTH bits
//   clear    - 1: load sign-extended in_data, 0: accumulate
//   sum_out  - next accumulator value
//   overflow - add saturated (always 0 without ACC_SATURATE_EN)
module psum_lane_adder
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = PSUM_ACC_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic                  overflow
);

  logic [ACC_WIDTH-1:0] in_ext;

  always_comb begin
    in_ext = ACC_WIDTH'($signed(in_data));
  end

`ifdef ACC_SATURATE_EN
  // One guard bit: a signed overflow shows as the two top bits differing.
  logic [ACC_WIDTH:0] sum_wide;

  always_comb begin
    sum_wide = {acc_in[ACC_WIDTH-1], acc_in} + {in_ext[ACC_WIDTH-1], in_ext};
    sum_out  = sum_wide[ACC_WIDTH-1:0];
    overflow = 1'b0;
    if (clear) begin
      sum_out = in_ext;
    end else if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      overflow = 1'b1;
      sum_out  = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum_out  = clear ? in_ext : acc_in + in_ext;
    overflow = 1'b0;
  end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Bank of NO_VECTORS accumulator vectors (VECTOR_WIDTH signed lanes each).
// Input vectors are added into (or overwrite) a selected vector; a drain
// request streams every vector out in index order, clearing each one as it
// is accepted downstream.
// Build option: ACC_SATURATE_EN -- saturating adds with sticky AccOverflow;
// default build wraps and AccOverflow stays 0.
// Ports:
//   CLK, SYNC_RST        - clock, synchronous active-high reset
//   EN                   - global enable; 0 freezes all state
//   InValid/InReady      - input handshake
//   Inputs               - VECTOR_WIDTH x DATA_WIDTH signed partial sums
//   InputVectorSelector  - target vector (out-of-range transfers dropped)
//   InClear              - overwrite instead of accumulate
//   DrainStart           - begin sequential drain (IDLE only)
//   OutValid/OutReady    - output handshake
//   OutVectorIndex       - index of Result
//   Result               - VECTOR_WIDTH x ACC_WIDTH drained vector
//   DrainDone            - one-cycle pulse after the last vector is taken
//   AccOverflow          - sticky saturation flag
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH          = PSUM_VECTOR_WIDTH_DEF,
  parameter int unsigned NO_VECTORS            = PSUM_NO_VECTORS_DEF,
  parameter int unsigned DATA_WIDTH            = PSUM_DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH             = PSUM_ACC_WIDTH_DEF,
  parameter int unsigned VECTOR_SELECTOR_WIDTH = PSUM_VECTOR_SELECTOR_WIDTH_DEF
) (
  input  logic                                    CLK,
  input  logic                                    SYNC_RST,
  input  logic                                    EN,
  input  logic                                    InValid,
  output logic                                    InReady,
  input  logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] Inputs,
  input  logic [VECTOR_SELECTOR_WIDTH-1:0]        InputVectorSelector,
  input  logic                                    InClear,
  input  logic                                    DrainStart,
  output logic                                    OutValid,
  input  logic                                    OutReady,
  output logic [VECTOR_SELECTOR_WIDTH-1:0]        OutVectorIndex,
  output logic [VECTOR_WIDTH-1:0][ACC_WIDTH-1:0]  Result,
  output logic                                    DrainDone,
  output logic                                    AccOverflow
);

  localparam int unsigned IDX_W = (NO_VECTORS > 1) ? $clog2(NO_VECTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_VECTORS - 1);

  typedef logic [VECTOR_WIDTH-1:0][ACC_WIDTH-1:0] vec_t;

  psum_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  vec_t [NO_VECTORS-1:0]    acc_q, acc_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;

  logic                     in_ready;
  logic                     sel_ok;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;
  logic                     out_valid;
  logic                     out_fire;
  vec_t                     lane_sum;
  logic [VECTOR_WIDTH-1:0]  lane_ovf;

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && EN;
    sel_ok    = 32'(InputVectorSelector) < NO_VECTORS;
    wr_en     = InValid && in_ready && sel_ok;
    // Out-of-range selectors alias to vector 0 only to keep the read in
    // bounds; wr_en is low so nothing is written.
    wr_idx    = sel_ok ? IDX_W'(InputVectorSelector) : '0;
    out_valid = (state_q == ST_DRAIN) && EN;
    out_fire  = out_valid && OutReady;
  end

  for (genvar l = 0; l < VECTOR_WIDTH; l++) begin : g_lane
    psum_lane_adder #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .in_data  (Inputs[l]),
      .acc_in   (acc_q[wr_idx][l]),
      .clear    (InClear),
      .sum_out  (lane_sum[l]),
      .overflow (lane_ovf[l])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (EN) begin
      if (wr_en) begin
        acc_d[wr_idx] = lane_sum;
        ovf_d         = ovf_q | (|lane_ovf);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (DrainStart) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            acc_d[idx_q] = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    InReady        = in_ready;
    OutValid       = out_valid;
    OutVectorIndex = VECTOR_SELECTOR_WIDTH'(idx_q);
    Result         = acc_q[idx_q];
    DrainDone      = done_q;
    AccOverflow    = ovf_q;
  end

endmodule
